// File: rtl/pad_in_filter_pkg.sv
// Shared types and defaults for the pad input filter.
// Optional feature macro: PAD_IN_FILTER_IRQ_EN (edge interrupt logic).
package pad_in_filter_pkg;

    // Per-channel interrupt source selection.
    typedef enum logic [1:0] {
        IRQ_NONE = 2'd0,
        IRQ_RISE = 2'd1,
        IRQ_FALL = 2'd2,
        IRQ_BOTH = 2'd3
    } irq_mode_e;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_WIDTH   = 8;

    // True when an edge pulse matches the programmed interrupt mode.
    function automatic logic irq_hit(irq_mode_e mode, logic rise, logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            IRQ_RISE: hit = rise;
            IRQ_FALL: hit = fall;
            IRQ_BOTH: hit = rise | fall;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pad_in_filter_chan.sv
// One pad channel: synchroniser, debounce counter, edge pulses and,
// when PAD_IN_FILTER_IRQ_EN is defined, a sticky interrupt pending bit.
module pad_in_filter_chan
    import pad_in_filter_pkg::*;
#(
    parameter int unsigned SyncStages = DEF_SYNC_STAGES,  // legal 2..4
    parameter int unsigned CntWidth   = DEF_CNT_WIDTH,
    parameter logic        ResetVal   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pad_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] debounce_cycles_i,
`ifdef PAD_IN_FILTER_IRQ_EN
    input  logic [1:0]          irq_mode_i,
    input  logic                irq_clr_i,
    output logic                irq_pending_o,
    output logic                irq_pending_next_o,
`endif
    output logic                pad_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  level_q;
    logic                  rise_q;
    logic                  fall_q;
    logic                  s;

    assign s = sync_q[SyncStages-1];

    // Shift the raw pad level through the synchroniser, independent of en_i.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SyncStages{ResetVal}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad_i};
        end
    end

    // Debounce: accept a new level once it has mismatched for D+1 edges.
    // The >= compare lets a lowered D take effect on the next mismatching edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= ResetVal;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!en_i || (s == level_q)) begin
                cnt_q <= '0;
            end else if (cnt_q >= debounce_cycles_i) begin
                level_q <= s;
                cnt_q   <= '0;
                rise_q  <= s;
                fall_q  <= ~s;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pad_o  = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef PAD_IN_FILTER_IRQ_EN
    logic pending_q;
    logic pending_d;

    // Next pending value: a matching edge wins over a simultaneous clear.
    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        pending_d = pending_q & ~irq_clr_i;
        if (irq_hit(irq_mode_e'(irq_mode_i), rise_q, fall_q)) begin
            pending_d = 1'b1;
        end
    end

    // Pending bit register; sets the cycle after the qualifying edge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign irq_pending_o      = pending_q;
    assign irq_pending_next_o = pending_d;
`endif

endmodule

// File: rtl/pad_in_filter.sv
// Pad input conditioner for NumPads channels: synchronise, debounce,
// and emit clean levels plus single-cycle rise/fall pulses.
// Optional feature macro: PAD_IN_FILTER_IRQ_EN adds per-channel edge
// interrupts (irq_mode_i, irq_clr_i, irq_pending_o, irq_o).
module pad_in_filter
    import pad_in_filter_pkg::*;
#(
    parameter int unsigned NumPads    = 8,
    parameter int unsigned SyncStages = DEF_SYNC_STAGES,
    parameter int unsigned CntWidth   = DEF_CNT_WIDTH,
    parameter logic        ResetVal   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumPads-1:0]   pad_i,
    input  logic [NumPads-1:0]   en_i,
    input  logic [CntWidth-1:0]  debounce_cycles_i,
`ifdef PAD_IN_FILTER_IRQ_EN
    input  logic [2*NumPads-1:0] irq_mode_i,
    input  logic [NumPads-1:0]   irq_clr_i,
    output logic [NumPads-1:0]   irq_pending_o,
    output logic                 irq_o,
`endif
    output logic [NumPads-1:0]   pad_o,
    output logic [NumPads-1:0]   rise_o,
    output logic [NumPads-1:0]   fall_o
);

`ifdef PAD_IN_FILTER_IRQ_EN
    logic [NumPads-1:0] pending_next;
    logic               irq_q;
`endif

    for (genvar g = 0; g < NumPads; g++) begin : g_chan
        pad_in_filter_chan #(
            .SyncStages (SyncStages),
            .CntWidth   (CntWidth),
            .ResetVal   (ResetVal)
        ) u_chan (
            .clk_i              (clk_i),
            .rst_i              (rst_i),
            .pad_i              (pad_i[g]),
            .en_i               (en_i[g]),
            .debounce_cycles_i  (debounce_cycles_i),
`ifdef PAD_IN_FILTER_IRQ_EN
            .irq_mode_i         (irq_mode_i[2*g +: 2]),
            .irq_clr_i          (irq_clr_i[g]),
            .irq_pending_o      (irq_pending_o[g]),
            .irq_pending_next_o (pending_next[g]),
`endif
            .pad_o              (pad_o[g]),
            .rise_o             (rise_o[g]),
            .fall_o             (fall_o[g])
        );
    end

`ifdef PAD_IN_FILTER_IRQ_EN
    // Summary interrupt registered from the next pending bits so it
    // changes on the same edge as irq_pending_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pending_next;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Scoreboard bench for pad_in_filter: stimulus pushes per-cycle expected
// channel states, a negedge monitor pops and compares them.
module tb_pad_in_filter;
    import pad_in_filter_pkg::*;

    localparam int NP = 8;

    typedef enum logic {K_CHAN, K_IRQ} kind_e;
    typedef struct {
        int         cyc;
        int         ch;
        kind_e      kind;
        logic [2:0] val;   // K_CHAN: {pad,rise,fall}; K_IRQ: {0,pending,irq}
        string      name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] pad = 8'hFF;
    logic [NP-1:0] en = 8'hFF;
    logic [7:0]    dcyc = 8'd3;
    logic [NP-1:0] pad_o, rise_o, fall_o;
`ifdef PAD_IN_FILTER_IRQ_EN
    logic [2*NP-1:0] irq_mode = '0;
    logic [NP-1:0]   irq_clr = '0;
    logic [NP-1:0]   irq_pending;
    logic            irq;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    pad_in_filter #(.NumPads(NP)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pad_i             (pad),
        .en_i              (en),
        .debounce_cycles_i (dcyc),
`ifdef PAD_IN_FILTER_IRQ_EN
        .irq_mode_i        (irq_mode),
        .irq_clr_i         (irq_clr),
        .irq_pending_o     (irq_pending),
        .irq_o             (irq),
`endif
        .pad_o             (pad_o),
        .rise_o            (rise_o),
        .fall_o            (fall_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Expect channel ch to show {pad,rise,fall} on cycles from..to.
    task automatic exp_chan(string name, int ch, int from, int to, logic p, logic r, logic f);
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.cyc = c; e.ch = ch; e.kind = K_CHAN; e.val = {p, r, f}; e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic exp_irq(string name, int ch, int c, logic pend, logic irq_bit);
        exp_t e;
        e.cyc = c; e.ch = ch; e.kind = K_IRQ; e.val = {1'b0, pend, irq_bit}; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due on this cycle, then drop it.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [2:0] act;
                act = 3'b000;
                if (sb[i].kind == K_CHAN) begin
                    act = {pad_o[sb[i].ch], rise_o[sb[i].ch], fall_o[sb[i].ch]};
                end else begin
`ifdef PAD_IN_FILTER_IRQ_EN
                    act = {1'b0, irq_pending[sb[i].ch], irq};
`endif
                end
                if (sb[i].cyc < cyc) check({sb[i].name, "_missed"}, 32'(sb[i].cyc), 32'(cyc));
                else                 check(sb[i].name, 32'(act), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state, then release with all pads high and D=3.
        tick(2);
        t = cyc;
        for (int ch = 0; ch < NP; ch++) exp_chan("reset_state", ch, t + 1, t + 4, 1'b1, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(3);

        // Clean falling step on ch0, D=3: update after 2+3+1 cycles.
        t = cyc;
        exp_chan("step_pre", 0, t + 1, t + 5, 1'b1, 1'b0, 1'b0);
        exp_chan("step_fall", 0, t + 6, t + 6, 1'b0, 1'b0, 1'b1);
        exp_chan("step_post", 0, t + 7, t + 8, 1'b0, 1'b0, 1'b0);
        pad[0] = 1'b0;
        tick(9);

        // 3-cycle glitch on ch1 is rejected.
        t = cyc;
        exp_chan("glitch3", 1, t + 1, t + 10, 1'b1, 1'b0, 1'b0);
        pad[1] = 1'b0;
        tick(3);
        pad[1] = 1'b1;
        tick(8);

        // 4-cycle low pulse on ch1: fall, then rise 6 cycles after pulse end.
        t = cyc;
        exp_chan("pulse4_pre", 1, t + 1, t + 5, 1'b1, 1'b0, 1'b0);
        exp_chan("pulse4_fall", 1, t + 6, t + 6, 1'b0, 1'b0, 1'b1);
        exp_chan("pulse4_low", 1, t + 7, t + 9, 1'b0, 1'b0, 1'b0);
        exp_chan("pulse4_rise", 1, t + 10, t + 10, 1'b1, 1'b1, 1'b0);
        exp_chan("pulse4_post", 1, t + 11, t + 11, 1'b1, 1'b0, 1'b0);
        pad[1] = 1'b0;
        tick(4);
        pad[1] = 1'b1;
        tick(9);

        // D=0: rising step on ch0 visible after 3 cycles.
        t = cyc;
        exp_chan("d0_pre", 0, t + 1, t + 2, 1'b0, 1'b0, 1'b0);
        exp_chan("d0_rise", 0, t + 3, t + 3, 1'b1, 1'b1, 1'b0);
        exp_chan("d0_post", 0, t + 4, t + 4, 1'b1, 1'b0, 1'b0);
        dcyc = 8'd0;
        pad[0] = 1'b1;
        tick(6);

        // D=10, lowered to 2 once cnt reaches 5: update on the next edge.
        t = cyc;
        exp_chan("dchg_pre", 0, t + 1, t + 7, 1'b1, 1'b0, 1'b0);
        exp_chan("dchg_fall", 0, t + 8, t + 8, 1'b0, 1'b0, 1'b1);
        exp_chan("dchg_post", 0, t + 9, t + 9, 1'b0, 1'b0, 1'b0);
        dcyc = 8'd10;
        pad[0] = 1'b0;
        tick(7);
        dcyc = 8'd2;
        tick(4);
        dcyc = 8'd3;

        // Disabled ch2 holds while pad toggles; re-enable counts D+1 edges.
        t = cyc;
        exp_chan("en_hold", 2, t + 1, t + 23, 1'b1, 1'b0, 1'b0);
        exp_chan("en_fall", 2, t + 24, t + 24, 1'b0, 1'b0, 1'b1);
        exp_chan("en_post", 2, t + 25, t + 25, 1'b0, 1'b0, 1'b0);
        en[2] = 1'b0;
        pad[2] = 1'b0;
        tick(5);
        pad[2] = 1'b1;
        tick(5);
        pad[2] = 1'b0;
        tick(10);
        en[2] = 1'b1;
        tick(7);

        // Reset mid-count on ch0 and ch2: back to ResetVal, no pulses.
        t = cyc;
        for (int ch = 0; ch < NP; ch++) begin
            logic lvl;
            lvl = (ch == 0 || ch == 2) ? 1'b0 : 1'b1;
            exp_chan("rst_pre", ch, t + 1, t + 4, lvl, 1'b0, 1'b0);
            exp_chan("rst_mid", ch, t + 5, t + 12, 1'b1, 1'b0, 1'b0);
        end
        pad = 8'hFF;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);

`ifdef PAD_IN_FILTER_IRQ_EN
        // ch3 mode RISE, ch4 mode NONE; both see the same fall/rise pair twice.
        t = cyc;
        irq_mode[2*3 +: 2] = IRQ_RISE;
        irq_mode[2*4 +: 2] = IRQ_NONE;
        exp_irq("irq_on_fall", 3, t + 7, 1'b0, 1'b0);
        exp_irq("irq_rise_cyc", 3, t + 16, 1'b0, 1'b0);
        exp_chan("irq_rise_pulse", 3, t + 16, t + 16, 1'b1, 1'b1, 1'b0);
        exp_irq("irq_set", 3, t + 17, 1'b1, 1'b1);
        exp_irq("irq_none", 4, t + 17, 1'b0, 1'b1);
        exp_irq("irq_sticky", 3, t + 20, 1'b1, 1'b1);
        exp_irq("irq_clr", 3, t + 21, 1'b0, 1'b0);
        exp_irq("irq_set_clr", 3, t + 37, 1'b1, 1'b1);
        exp_irq("irq_none2", 4, t + 37, 1'b0, 1'b1);
        exp_irq("irq_hold", 3, t + 38, 1'b1, 1'b1);
        pad[3] = 1'b0; pad[4] = 1'b0;
        tick(10);
        pad[3] = 1'b1; pad[4] = 1'b1;
        tick(10);
        irq_clr[3] = 1'b1;
        pad[3] = 1'b0; pad[4] = 1'b0;
        tick(1);
        irq_clr[3] = 1'b0;
        tick(9);
        pad[3] = 1'b1; pad[4] = 1'b1;
        tick(6);
        irq_clr[3] = 1'b1;
        tick(1);
        irq_clr[3] = 1'b0;
        tick(3);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 50 && sb.size() != 0; k++) tick(1);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
